sync_fifo_wm: RTL and testbench

- Single-clock, parametrised valid/ready FIFO; the synchronous successor of the team's gray-pointer CDC FIFO, for buffering inside one clock domain.
- Generalised in data width and depth, with two output modes: first-word fall-through or registered output.
- Adds features the CDC FIFO lacks: exact fill level, programmable almost-full/almost-empty watermarks, synchronous flush, and a sticky overflow-attempt flag.

---
 rtl/sync_fifo_wm.sv | 139 +++++++++++++
 tb/tb_sync_fifo_wm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_wm.sv
// Single-clock valid/ready FIFO with fill level, watermark flags, synchronous
// flush and a sticky overflow-attempt flag.
//
// Ports:
//   clk            - clock, rising edge
//   reset          - asynchronous active-low reset
//   flush_i        - synchronous flush, discards all contents
//   src_data_i     - write payload
//   src_valid_i    - write request
//   src_ready_o    - FIFO can accept a write (registered state and flush_i only)
//   dst_data_o     - read payload (don't-care while dst_valid_o is low)
//   dst_valid_o    - read data available
//   dst_ready_i    - consumer accepts
//   fill_o         - entries held in the storage array (output register excluded)
//   almost_full_o  - fill_o >= AlmostFullTh
//   almost_empty_o - fill_o <= AlmostEmptyTh
//   ovf_o          - sticky: a write was attempted while full
//
// FallThrough=1 drives dst_data_o straight from storage. FallThrough=0 adds an
// output register stage, so total capacity becomes Depth+1.
module sync_fifo_wm #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrDepth     = 3,
  parameter bit          FallThrough   = 1'b1,
  parameter int unsigned AlmostFullTh  = 6,
  parameter int unsigned AlmostEmptyTh = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush_i,
  input  logic [DataWidth-1:0] src_data_i,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  output logic [DataWidth-1:0] dst_data_o,
  output logic                 dst_valid_o,
  input  logic                 dst_ready_i,
  output logic [AddrDepth:0]   fill_o,
  output logic                 almost_full_o,
  output logic                 almost_empty_o,
  output logic                 ovf_o
);

  localparam int unsigned Depth = 2 ** AddrDepth;
  localparam int unsigned PtrW  = AddrDepth + 1;

  localparam logic [AddrDepth:0] PtrOne = {{AddrDepth{1'b0}}, 1'b1};
  localparam logic [AddrDepth:0] AfTh   = PtrW'(AlmostFullTh);
  localparam logic [AddrDepth:0] AeTh   = PtrW'(AlmostEmptyTh);

  logic [AddrDepth:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrDepth:0]   rd_ptr_q, rd_ptr_d;
  logic                 ovf_q, ovf_d;
  logic [DataWidth-1:0] mem_q [Depth];

  logic full, empty, push, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrDepth] != rd_ptr_q[AddrDepth]) &&
                 (wr_ptr_q[AddrDepth-1:0] == rd_ptr_q[AddrDepth-1:0]);

  assign src_ready_o = ~full & ~flush_i;
  assign push        = src_valid_i & src_ready_o;

  assign fill_o         = wr_ptr_q - rd_ptr_q;
  assign almost_full_o  = (fill_o >= AfTh);
  assign almost_empty_o = (fill_o <= AeTh);
  assign ovf_o          = ovf_q;

  if (FallThrough) begin : g_fall_through
    assign dst_valid_o = ~empty;
    assign dst_data_o  = mem_q[rd_ptr_q[AddrDepth-1:0]];
    assign rd_en       = ~empty & dst_ready_i;
  end else begin : g_out_reg
    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] data_q, data_d;

    // Refill the output register whenever it is free or being drained this cycle.
    assign rd_en = ~empty & (~valid_q | dst_ready_i);

    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
        valid_d = 1'b0;
      end else if (rd_en) begin
        valid_d = 1'b1;
        data_d  = mem_q[rd_ptr_q[AddrDepth-1:0]];
      end else if (valid_q && dst_ready_i) begin
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
      end
    end

    assign dst_valid_o = valid_q;
    assign dst_data_o  = data_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (rd_en) rd_ptr_d = rd_ptr_q + PtrOne;
      if (src_valid_i && full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is intentionally not reset; push is already masked by flush_i.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AddrDepth-1:0]] <= src_data_i;
  end

endmodule

// File: tb/tb_sync_fifo_wm.sv
// Drives a fall-through instance (a_*) and a registered-output instance (b_*)
// with the same stimulus and compares both against queue-based models.
module tb_sync_fifo_wm;
  localparam int unsigned DW = 32;
  localparam int unsigned AD = 3;
  localparam int unsigned D  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush, src_valid, dst_ready;
  logic [DW-1:0] src_data;

  logic          a_ready, a_valid, a_af, a_ae, a_ovf;
  logic [DW-1:0] a_data;
  logic [AD:0]   a_fill;
  logic          b_ready, b_valid, b_af, b_ae, b_ovf;
  logic [DW-1:0] b_data;
  logic [AD:0]   b_fill;

  always #5 clk = ~clk;

  sync_fifo_wm #(.DataWidth(DW), .AddrDepth(AD), .FallThrough(1'b1),
                 .AlmostFullTh(6), .AlmostEmptyTh(1)) u_dut_ft (
    .clk(clk), .reset(reset), .flush_i(flush),
    .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(a_ready),
    .dst_data_o(a_data), .dst_valid_o(a_valid), .dst_ready_i(dst_ready),
    .fill_o(a_fill), .almost_full_o(a_af), .almost_empty_o(a_ae), .ovf_o(a_ovf)
  );

  sync_fifo_wm #(.DataWidth(DW), .AddrDepth(AD), .FallThrough(1'b0),
                 .AlmostFullTh(6), .AlmostEmptyTh(1)) u_dut_reg (
    .clk(clk), .reset(reset), .flush_i(flush),
    .src_data_i(src_data), .src_valid_i(src_valid), .src_ready_o(b_ready),
    .dst_data_o(b_data), .dst_valid_o(b_valid), .dst_ready_i(dst_ready),
    .fill_o(b_fill), .almost_full_o(b_af), .almost_empty_o(b_ae), .ovf_o(b_ovf)
  );

  int checks = 0;
  int errors = 0;
  int b_acc  = 0;

  // Reference models: qa is the fall-through FIFO contents; qb is the storage of
  // the registered variant, with rvb/rdb standing for the word already presented.
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  bit            ovfa, ovfb, rvb;
  logic [DW-1:0] rdb;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_eq("a_ready", a_ready, (qa.size() < D) && !flush);
    check_eq("a_valid", a_valid, qa.size() != 0);
    if (qa.size() != 0) check_eq("a_data", a_data, qa[0]);
    check_eq("a_fill", a_fill, qa.size());
    check_eq("a_af", a_af, qa.size() >= 6);
    check_eq("a_ae", a_ae, qa.size() <= 1);
    check_eq("a_ovf", a_ovf, ovfa);
    check_eq("b_ready", b_ready, (qb.size() < D) && !flush);
    check_eq("b_valid", b_valid, rvb);
    if (rvb) check_eq("b_data", b_data, rdb);
    check_eq("b_fill", b_fill, qb.size());
    check_eq("b_af", b_af, qb.size() >= 6);
    check_eq("b_ae", b_ae, qb.size() <= 1);
    check_eq("b_ovf", b_ovf, ovfb);
  endtask

  task automatic model_step();
    int na, nb;
    bit pusha, popa, pushb, loadb;
    na = qa.size();
    nb = qb.size();
    if (flush) begin
      qa.delete();
      ovfa = 1'b0;
      qb.delete();
      rvb  = 1'b0;
      ovfb = 1'b0;
    end else begin
      if (src_valid && na == D) ovfa = 1'b1;
      popa  = (na != 0) && dst_ready;
      pusha = src_valid && (na < D);
      if (popa) void'(qa.pop_front());
      if (pusha) qa.push_back(src_data);

      if (src_valid && nb == D) ovfb = 1'b1;
      pushb = src_valid && (nb < D);
      loadb = (nb != 0) && (!rvb || dst_ready);
      if (loadb) begin
        rdb = qb.pop_front();
        rvb = 1'b1;
      end else if (rvb && dst_ready) begin
        rvb = 1'b0;
      end
      if (pushb) qb.push_back(src_data);
    end
  endtask

  // Called at posedge+1: drive, check settled outputs, advance the model, clock.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    src_valid = v;
    src_data  = d;
    dst_ready = r;
    flush     = f;
    #3;
    check_outputs();
    if (v && b_ready) b_acc++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_a_ready"}, a_ready, 1'b1);
    check_eq({tag, "_a_valid"}, a_valid, 1'b0);
    check_eq({tag, "_a_fill"}, a_fill, 0);
    check_eq({tag, "_a_af"}, a_af, 1'b0);
    check_eq({tag, "_a_ae"}, a_ae, 1'b1);
    check_eq({tag, "_a_ovf"}, a_ovf, 1'b0);
    check_eq({tag, "_b_valid"}, b_valid, 1'b0);
    check_eq({tag, "_b_fill"}, b_fill, 0);
    check_eq({tag, "_b_data"}, b_data, 0);
    check_eq({tag, "_b_ovf"}, b_ovf, 1'b0);
  endtask

  task automatic clear_models();
    qa.delete();
    qb.delete();
    ovfa = 1'b0;
    ovfb = 1'b0;
    rvb  = 1'b0;
    rdb  = '0;
  endtask

  task automatic drain();
    repeat (12) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    src_valid = 1'b0;
    dst_ready = 1'b0;
    src_data  = '0;
    clear_models();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    reset = 1'b1;

    // Fill the fall-through FIFO back-to-back with 1..8.
    for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    check_eq("full_fill", a_fill, 8);
    check_eq("full_ready", a_ready, 1'b0);
    check_eq("full_af", a_af, 1'b1);

    // Write attempt while full sets the sticky flag.
    cycle(1'b1, 32'hdead_beef, 1'b0, 1'b0);
    check_eq("ovf_set", a_ovf, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_eq("ovf_sticky", a_ovf, 1'b1);

    // Pop everything; order and flags come from the model.
    for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("drained_valid", a_valid, 1'b0);
    drain();

    // Full-throughput streaming across several pointer wraps.
    for (int i = 0; i < 40; i++) cycle(1'b1, 32'h100 + DW'(i), 1'b1, 1'b0);
    check_eq("stream_fill", a_fill, 1);
    drain();

    // Registered-output latency.
    cycle(1'b1, 32'ha5, 1'b0, 1'b0);
    check_eq("b_lat1", b_valid, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_eq("b_lat2", b_valid, 1'b1);
    check_eq("b_lat2_data", b_data, 32'ha5);
    drain();

    // Registered-output capacity is Depth+1.
    b_acc = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'h200 + DW'(i), 1'b0, 1'b0);
    check_eq("b_accept9", b_acc, 9);
    drain();

    // Flush with a simultaneous push and dst handshake.
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h300 + DW'(i), 1'b0, 1'b0);
    cycle(1'b1, 32'h55, 1'b1, 1'b1);
    check_eq("flush_a_fill", a_fill, 0);
    check_eq("flush_a_valid", a_valid, 1'b0);
    check_eq("flush_a_ovf", a_ovf, 1'b0);
    check_eq("flush_b_valid", b_valid, 1'b0);
    check_eq("flush_b_fill", b_fill, 0);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    drain();

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset between clock edges in the middle of a burst.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h400 + DW'(i), 1'b0, 1'b0);
    src_valid = 1'b0;
    flush     = 1'b0;
    dst_ready = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals("async");
    clear_models();
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle(1'b1, 32'h77, 1'b0, 1'b0);
    check_eq("post_rst_a_data", a_data, 32'h77);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_eq("post_rst_b_data", b_data, 32'h77);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
